// File: rtl/dac_arb_pkg.sv
// Shared state encoding, counter width and helpers for the DAC sample arbiter.
package dac_arb_pkg;

    localparam int unsigned UNDERRUN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        OFFER = 2'd2
    } arb_state_e;

    function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping at N.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            gnt_valid_o,
    output logic [ID_W-1:0] gnt_id_o
);

    int idx;

    // Scan farthest-first so the nearest requester after ptr_i overwrites last.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = '0;
        idx         = 0;
        for (int k = int'(N); k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % int'(N);
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dac_sample_arbiter.sv
// Round-robin share of one SPI DAC driver between NUM_SRC stream sources,
// with one holding register per source and a saturating underrun counter.
module dac_sample_arbiter
    import dac_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SRC_ID_W = $clog2(NUM_SRC)
) (
    input  logic                      mclk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_SRC-1:0]        src_mask,
    input  logic [NUM_SRC-1:0]        s_axis_valid,
    output logic [NUM_SRC-1:0]        s_axis_ready,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_data,
    output logic                      m_axis_valid,
    input  logic                      m_axis_ready,
    output logic [DATA_W-1:0]         m_axis_data,
    output logic [SRC_ID_W-1:0]       grant_id,
    output logic [UNDERRUN_W-1:0]     underrun_cnt
);

    arb_state_e            state_q, state_d;
    logic [NUM_SRC-1:0]    hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]     hold_data_q [NUM_SRC];
    logic [DATA_W-1:0]     hold_data_d [NUM_SRC];
    logic [SRC_ID_W-1:0]   ptr_q, ptr_d;
    logic [SRC_ID_W-1:0]   win_q, win_d;
    logic [SRC_ID_W-1:0]   grant_q, grant_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_W-1:0]     m_data_q, m_data_d;
    logic [UNDERRUN_W-1:0] under_q, under_d;

    logic                  gnt_valid;
    logic [SRC_ID_W-1:0]   gnt_id;
    logic                  grant_fire;
    logic [NUM_SRC-1:0]    capture;
    logic [NUM_SRC-1:0]    take;

    assign s_axis_ready = {NUM_SRC{rst_n & en}} & src_mask & ~hold_valid_q;
    assign capture      = s_axis_valid & s_axis_ready;
    assign take         = grant_fire ? (NUM_SRC'(1) << gnt_id) : '0;

    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;
    assign grant_id     = grant_q;
    assign underrun_cnt = under_q;

    rr_arbiter #(
        .N    (NUM_SRC),
        .ID_W (SRC_ID_W)
    ) u_rr_arbiter (
        .req_i       (hold_valid_q & src_mask),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        win_d      = win_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        grant_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (gnt_valid) begin
                    grant_fire = 1'b1;
                    m_data_d   = hold_data_q[gnt_id];
                    win_d      = gnt_id;
                    m_valid_d  = 1'b1;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                // An offered sample is always delivered, even if en has dropped.
                if (m_axis_ready) begin
                    m_valid_d = 1'b0;
                    grant_d   = win_q;
                    ptr_d     = win_q;
                    state_d   = en ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        under_d = under_q;
        if (m_axis_ready && !m_valid_q) begin
            under_d = sat_inc(under_q);
        end
    end

    // A fresh capture beats the clear from a same-cycle grant or mask drop.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (capture[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_data_d[i]  = s_axis_data[i*DATA_W +: DATA_W];
            end else if (take[i] || !src_mask[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_valid_q <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                hold_data_q[i] <= '0;
            end
            ptr_q        <= SRC_ID_W'(NUM_SRC - 1);
            win_q        <= '0;
            grant_q      <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            under_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            grant_q      <= grant_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            under_q      <= under_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_arbiter.sv
// Randomised and directed bench for dac_sample_arbiter with a transaction-level
// reference model feeding a scoreboard that a separate monitor drains.
module tb_dac_sample_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    mask;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [N*DW-1:0] s_data;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic [1:0]      gid;
    logic [15:0]     ucnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dac_sample_arbiter #(
        .NUM_SRC  (N),
        .DATA_W   (DW),
        .SRC_ID_W (2)
    ) dut (
        .mclk         (clk),
        .rst_n        (rst_n),
        .en           (en),
        .src_mask     (mask),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .s_axis_data  (s_data),
        .m_axis_valid (m_valid),
        .m_axis_ready (m_ready),
        .m_axis_data  (m_data),
        .grant_id     (gid),
        .underrun_cnt (ucnt)
    );

    // Reference model: per-source holds, one offered sample, last served source.
    bit          mh_v [N];
    logic [15:0] mh_d [N];
    bit          off_v;
    logic [15:0] off_d;
    int          off_id;
    int          last;
    int          m_gid;
    int          m_ucnt;
    logic [15:0] m_out;
    bit          en_prev;
    bit          m_cap [N];

    // Expected DUT outputs for the current cycle.
    logic [N-1:0] e_rdy;
    bit           e_mv;
    logic [15:0]  e_md;
    int           e_gid;
    int           e_ucnt;

    logic [15:0] exp_q [$];
    logic [15:0] seen_q [$];
    logic [15:0] want_q [$];
    bit          chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        int win;
        int idx;
        for (int i = 0; i < N; i++) begin
            e_rdy[i] = rst_n && en && mask[i] && !mh_v[i];
            m_cap[i] = 1'b0;
        end
        e_mv   = off_v;
        e_md   = m_out;
        e_gid  = m_gid;
        e_ucnt = m_ucnt;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mh_v[i] = 1'b0;
                mh_d[i] = '0;
            end
            off_v   = 1'b0;
            off_d   = '0;
            off_id  = 0;
            last    = N - 1;
            m_gid   = 0;
            m_ucnt  = 0;
            m_out   = '0;
            en_prev = 1'b0;
        end else begin
            // A grant needs en held over two edges and nothing already on offer.
            win = -1;
            if (!off_v && en_prev && en) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (last + k) % N;
                    if (win < 0 && mh_v[idx] && mask[idx]) win = idx;
                end
            end
            if (m_ready) begin
                if (off_v) begin
                    exp_q.push_back(off_d);
                    m_gid = off_id;
                    last  = off_id;
                    off_v = 1'b0;
                end else if (m_ucnt < 65535) begin
                    m_ucnt++;
                end
            end
            for (int i = 0; i < N; i++) m_cap[i] = e_rdy[i] && s_valid[i];
            if (win >= 0) begin
                off_v  = 1'b1;
                off_d  = mh_d[win];
                off_id = win;
                m_out  = mh_d[win];
            end
            for (int i = 0; i < N; i++) begin
                if (m_cap[i]) begin
                    mh_v[i] = 1'b1;
                    mh_d[i] = s_data[i*DW +: DW];
                end else if (i == win || !mask[i]) begin
                    mh_v[i] = 1'b0;
                end
            end
            en_prev = en;
        end
    endtask

    task automatic monitor_step();
        bit          dut_hs;
        logic [15:0] want;
        chk("s_axis_ready", 64'(s_ready), 64'(e_rdy));
        chk("m_axis_valid", 64'(m_valid), 64'(e_mv));
        chk("m_axis_data", 64'(m_data), 64'(e_md));
        chk("grant_id", 64'(gid), 64'(e_gid));
        chk("underrun_cnt", 64'(ucnt), 64'(e_ucnt));
        dut_hs = rst_n && m_valid && m_ready;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk("consume_handshake", 64'(dut_hs), 64'(1));
            if (dut_hs) begin
                chk("consume_data", 64'(m_data), 64'(want));
                seen_q.push_back(m_data);
            end
        end else if (dut_hs) begin
            chk("unexpected_consume", 64'(dut_hs), 64'(0));
            seen_q.push_back(m_data);
        end
    endtask

    always @(negedge clk) begin
        #1;
        model_step();
    end

    always @(negedge clk) begin
        #3;
        if (chk_on) monitor_step();
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic pulse();
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int p = 0; p < n; p++) begin
            tick(gap);
            pulse();
        end
    endtask

    task automatic fill_all(input logic [15:0] base);
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = base + 16'(i);
        s_valid = '1;
    endtask

    task automatic send(input int i, input logic [15:0] d);
        bit done;
        done       = 1'b0;
        s_valid[i] = 1'b1;
        s_data[i*DW +: DW] = d;
        for (int c = 0; c < 100 && !done; c++) begin
            tick(1);
            done = m_cap[i];
        end
        s_valid[i] = 1'b0;
        chk("send_accepted", 64'(done), 64'(1));
    endtask

    task automatic check_seen(input string name);
        chk(name, 64'(seen_q.size()), 64'(want_q.size()));
        for (int i = 0; i < seen_q.size() && i < want_q.size(); i++) begin
            chk(name, 64'(seen_q[i]), 64'(want_q[i]));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        mask    = '1;
        m_ready = 1'b0;
        s_data  = '0;
        fill_all(16'h1000);
        tick(2);
        chk_on = 1'b1;
        tick(3);
        chk("reset_ready", 64'(s_ready), 64'(0));
        chk("reset_underrun", 64'(ucnt), 64'(0));

        // Round robin from reset, all four sources kept full.
        seen_q.delete();
        rst_n = 1'b1;
        pulses(5, 19);
        tick(3);
        want_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1000};
        check_seen("rr_order");
        chk("rr_grant_id", 64'(gid), 64'(0));

        // Three pulses with nothing to send.
        s_valid = '0;
        do_reset();
        seen_q.delete();
        pulses(3, 5);
        tick(3);
        chk("underrun_3", 64'(ucnt), 64'(3));
        chk("underrun_no_valid", 64'(m_valid), 64'(0));
        chk("underrun_no_consume", 64'(seen_q.size()), 64'(0));

        // Masked sources 1 and 3 never served.
        mask = 4'b0101;
        fill_all(16'h2000);
        do_reset();
        seen_q.delete();
        pulses(6, 14);
        tick(3);
        want_q = '{16'h2000, 16'h2002, 16'h2000, 16'h2002, 16'h2000, 16'h2002};
        check_seen("mask_alternate");

        // Hold 2 full when its mask bit drops: it must never be emitted.
        s_valid = '0;
        do_reset();
        seen_q.delete();
        s_data[0*DW +: DW] = 16'h00A0;
        s_data[2*DW +: DW] = 16'hBEEF;
        s_valid = 4'b0101;
        tick(1);
        s_valid = '0;
        tick(3);
        mask = 4'b0001;
        tick(3);
        pulses(3, 6);
        tick(3);
        want_q = '{16'h00A0};
        check_seen("mask_discard");

        // Enable dropped while a sample is on offer.
        mask = '1;
        do_reset();
        seen_q.delete();
        send(1, 16'h5555);
        tick(3);
        en = 1'b0;
        fill_all(16'h6000);
        tick(5);
        chk("en_low_ready", 64'(s_ready), 64'(0));
        pulses(4, 6);
        tick(3);
        want_q = '{16'h5555};
        check_seen("en_drop");
        chk("en_drop_grant_id", 64'(gid), 64'(1));
        s_valid = '0;
        en      = 1'b1;

        // Source 1 refilled as soon as its hold is granted.
        do_reset();
        seen_q.delete();
        send(1, 16'h0111);
        send(1, 16'h0222);
        pulses(3, 10);
        tick(3);
        want_q = '{16'h0111, 16'h0222};
        check_seen("back_to_back");

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s_valid = N'($urandom & $urandom);
            s_data  = {$urandom, $urandom};
            m_ready = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) mask = N'($urandom);
            tick(1);
        end
        s_valid = '0;
        m_ready = 1'b0;
        en      = 1'b1;
        mask    = '1;
        pulses(8, 4);

        // Saturation of the underrun counter.
        do_reset();
        m_ready = 1'b1;
        tick(65540);
        m_ready = 1'b0;
        tick(2);
        chk("underrun_sat", 64'(ucnt), 64'(16'hFFFF));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_sample_arbiter.md
# dac_sample_arbiter

Round-robin scheduler that shares the single AD5541A SPI DAC driver between up to `NUM_SRC` AXI-stream sample producers. Each source gets a one-entry holding register, and the arbiter presents one granted sample at a time on the driver's stream input. The driver pulses ready once per DAC frame (every `MCLK_CYCLES_PER_DAC_CLK_CYCLE` mclk cycles). The arbiter also tags which source occupies each frame and counts frames that found no sample ready (underruns).

## Interface
- `NUM_SRC`, 4: number of requesters, 2..8.
- `DATA_W`, 16: sample width; must match the driver.
- `SRC_ID_W`, `$clog2(NUM_SRC)`: width of the grant tag.
- `mclk` in 1: single clock (50 MHz).
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: arbiter enable.
- `src_mask` in `NUM_SRC`: per-source participation enable.
- `s_axis_valid` in `NUM_SRC`: per-source sample valid.
- `s_axis_ready` out `NUM_SRC`: per-source ready.
- `s_axis_data` in `NUM_SRC*DATA_W`: source i occupies bits `[i*DATA_W +: DATA_W]`.
- `m_axis_valid` out 1: sample offered to the DAC driver.
- `m_axis_ready` in 1: driver's one-cycle load pulse.
- `m_axis_data` out `DATA_W`: offered sample.
- `grant_id` out `SRC_ID_W`: source of the last sample consumed by the driver.
- `underrun_cnt` out 16: saturating count of ready pulses that met no valid sample.

## Operation
- **Reset values** (`rst_n` = 0 at a clock edge): all holds empty; `m_axis_valid` = 0; `m_axis_data` = 0; `grant_id` = 0; `underrun_cnt` = 0; rr pointer = `NUM_SRC-1`, so source 0 wins first; state = IDLE.
- **Source ready:** `s_axis_ready[i] = rst_n & en & src_mask[i] & ~hold_valid[i]`. This is combinational from registers and inputs only.
- **Source handshake:** sample i is captured into hold i on a clock with `s_axis_valid[i]` & `s_axis_ready[i]`.
- **States:**
  - IDLE: entered when `en` = 0. Goes to ARB when `en` = 1.
  - ARB: if any `hold_valid & src_mask` is set, pick the first such source searching from ptr+1 with wrap-around. Load `m_axis_data` and the winner id, clear that hold, set `m_axis_valid`, go to OFFER. If none is set, stay in ARB.
  - OFFER: wait for `m_axis_ready`. On the pulse, clear `m_axis_valid`, update `grant_id` and ptr to the winner id, then go to ARB, or to IDLE if `en` = 0.
- **Underrun:** `m_axis_ready` = 1 while `m_axis_valid` = 0 increments `underrun_cnt`. It saturates at 0xFFFF. The driver then retransmits its previous code.
- **`en` dropped mid-operation:** a sample already in OFFER stays offered until consumed. Holds are retained. No new grants are made and no new samples are accepted.
- **Mask cleared on a source whose hold is full:** that hold is discarded on the next clock and is never granted.
- **Simultaneous capture and grant:** a source can be granted and accept a new sample in the same clock. The capture takes effect, because the ready was computed from the pre-clock hold state and the new sample wins over the clear.
- **Data path:** data passes through bit-exact. There is no arithmetic on samples.

## Timing
- Latency from a source handshake at edge t:
  - hold valid after t.
  - ARB grant at edge t+1.
  - `m_axis_valid` = 1 after t+1.
  - Best case, the driver's ready at edge t+2 consumes the sample.
- Minimum spacing between grants is 2 cycles (ARB then OFFER). This is far below the DAC frame period, so one sample per frame is sustained.
- Fairness: with all N sources continuously full, the grant order is 0, 1, …, N-1 repeating, one per DAC frame.
- `grant_id` and `underrun_cnt` update on the same edge as the ready pulse.

## Structure
- **Package `dac_arb_pkg`:** holds the `arb_state_e` enum (IDLE, ARB, OFFER) and the `UNDERRUN_W` = 16 constant.
- **Sub-module `rr_arbiter`:** a parameterised combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: gnt_valid, gnt_id.
  - The FSM, holds, and counters stay in `dac_sample_arbiter`.

## Test plan
- **Reset:** hold `rst_n` low with all sources valid → every `s_axis_ready` = 0 and every output at its reset value. Release → source 0 is granted first.
- **Round-robin:** 4 sources full with data 0x1000+i, driver pulsing every 100 cycles → consumed order 0x1000, 0x1001, 0x1002, 0x1003, 0x1000; `grant_id` tracks the source.
- **Underrun:** all sources idle for 3 driver pulses → `underrun_cnt` = 3 and `m_axis_valid` stays 0. Force 70000 underruns → the count saturates at 0xFFFF.
- **Mask:** `src_mask` = 4'b0101 with all sources full → only sources 0 and 2 alternate. Clearing bit 2 while hold 2 is full → sample 2 is never emitted.
- **Enable drop:** deassert `en` during OFFER → the offered sample is still consumed on the next pulse, then no further grants and all readies stay 0.
- **Back-to-back:** source 1 re-asserts valid in the cycle its hold is granted → the new sample is captured and granted in the next round, with no loss or duplication.
